ads131_frame_unpacker: RTL and testbench
========================================

Name: ads131_frame_unpacker

Overview:
Sits directly downstream of the SPI master that clocks ADS131A0x data frames. It consumes the 32-bit words that master assembles from MISO: one status word, then one word per ADC channel. It checks the status word and extracts each channel's 24-bit two's-complement sample, sign-extending it to 32 bits. It then streams the samples out one channel at a time over a valid/ready interface, for the downstream filter/packetiser.

Parameters:
NUM_CHANNELS, 4, channel words per frame after the status word (legal 1..8)
STATUS_MASK, 16'hFF00, bits of status word[31:16] that are checked
STATUS_EXPECT, 16'h2200, required value of (status[31:16] & STATUS_MASK)

Ports:
system_clock  in  1  single clock for all logic
reset  in  1  asynchronous, active-high; clears all state
frame_start  in  1  one-cycle pulse marking the start of a new frame (issued by the SPI master at CS assertion)
word_valid  in  1  one-cycle pulse; word_data holds a complete received 32-bit word
word_data  in  32  received word, MSB first as shifted in
sample_valid  out  1  sample_data/sample_channel/sample_last are valid
sample_ready  in  1  downstream accepts the sample when high with sample_valid
sample_data  out  32  channel sample: {{8{word[31]}}, word[31:8]}
sample_channel  out  3  channel index 0..NUM_CHANNELS-1
sample_last  out  1  high with the last channel of the frame
status_word  out  16  last captured status word[31:16]
status_valid  out  1  one-cycle pulse when status_word updates
status_error  out  1  one-cycle pulse when a status word fails the check
abort_count  out  8  saturating count of frames restarted mid-capture
overrun_count  out  8  saturating count of frames dropped while emitting

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, buffer contents don't-care (not observable).
- States: IDLE, STATUS, CHANNELS, EMIT. Internal regs: ch_cnt (3b), emit_idx (3b), buffer[NUM_CHANNELS] x 32.
- IDLE: frame_start -> STATUS. word_valid ignored.
- STATUS:
  - On word_valid: status_word <= word_data[31:16], and status_valid pulses the next cycle.
  - If (word_data[31:16] & STATUS_MASK) == STATUS_EXPECT: go to CHANNELS with ch_cnt=0.
  - Otherwise: status_error pulses the same cycle as status_valid, and the state returns to IDLE. The frame is discarded; no samples are emitted.
- CHANNELS:
  - On word_valid: buffer[ch_cnt] <= sign-extended word_data[31:8] (word_data[7:0] discarded), and ch_cnt increments.
  - On the word with ch_cnt == NUM_CHANNELS-1: go to EMIT with emit_idx=0.
- EMIT:
  - sample_valid=1, sample_data=buffer[emit_idx], sample_channel=emit_idx, sample_last=(emit_idx==NUM_CHANNELS-1).
  - First sample_valid is asserted exactly 1 cycle after the last channel's word_valid.
  - On sample_valid & sample_ready: emit_idx increments, and one sample is transferred per cycle if ready is held high.
  - After the handshake with sample_last=1: sample_valid deasserts the next cycle and the state returns to IDLE.
  - Outputs hold stable while sample_valid & !sample_ready (AXI-stream rule); sample_valid never drops without a handshake except on reset.
- frame_start in STATUS or CHANNELS: the partial frame is discarded, abort_count increments (saturates at 255), and the state goes to STATUS. Any word_valid in the same cycle is ignored.
- frame_start in EMIT: the new frame is not captured, overrun_count increments (saturates at 255), and EMIT continues unaffected. Later word_valids are ignored until IDLE is reached.
- frame_start in IDLE with word_valid in the same cycle: go to STATUS; the word is ignored.
- Asynchronous reset mid-frame or mid-emit: outputs clear immediately, including sample_valid=0. A handshake pending in that cycle does not occur.
- Counters never wrap: 255 + event = 255.

Test Plan:
- Nominal frame, NUM_CHANNELS=4, ready=1: frame_start, then words 32'h2200_0000, 32'h7FFFFF00, 32'h80000000, 32'h00000100, 32'hFFFFFFAB -> status_valid with status_word=16'h2200. Samples then appear on 4 consecutive cycles, starting 1 cycle after the last word: 32'h007FFFFF, 32'hFF800000, 32'h00000001, 32'hFFFFFFFF. Channels are 0..3, and sample_last is high on channel 3 only.
- Backpressure: same frame, with sample_ready low for 5 cycles on channel 1 -> channel 1 data and index held constant for all 5 cycles; no sample is lost or duplicated.
- Bad status: status word 32'h0655_0000 -> status_valid and status_error pulse together; the following channel words produce no sample_valid, and the state returns to IDLE.
- Abort: frame_start, status OK, 2 channel words, then frame_start followed by a full valid frame -> abort_count=1. Only the second frame's 4 samples are emitted.
- Overrun: during EMIT with sample_ready=0, pulse frame_start 300 times -> overrun_count saturates at 255, and the original frame is still emitted intact.
- Reset mid-EMIT: assert reset while sample_valid=1 -> all outputs 0 immediately. After release, a fresh frame is processed normally.

Source files
------------

// File: rtl/ads131_frame_unpacker.sv
// ads131_frame_unpacker
//
// Unpacks ADS131A0x data frames delivered as 32-bit words by the upstream
// SPI master: one status word followed by NUM_CHANNELS channel words. The
// status word's upper half is checked against STATUS_EXPECT under
// STATUS_MASK. Each channel's 24-bit two's-complement sample (word[31:8]) is
// sign-extended to 32 bits, buffered, and then streamed out one channel per
// transfer.
//
// Ports:
//   system_clock   single clock for all logic
//   reset          asynchronous, active-high; clears all state
//   frame_start    one-cycle pulse at CS assertion, starts a new frame
//   word_valid     one-cycle pulse; word_data holds a complete word
//   word_data      received 32-bit word, MSB first as shifted in
//   sample_valid   sample_data/sample_channel/sample_last are valid
//   sample_ready   downstream accepts the sample
//   sample_data    {{8{word[31]}}, word[31:8]} for the current channel
//   sample_channel channel index 0..NUM_CHANNELS-1
//   sample_last    high with the last channel of the frame
//   status_word    last captured status word[31:16]
//   status_valid   one-cycle pulse when status_word updates
//   status_error   one-cycle pulse when a status word fails the check
//   abort_count    saturating count of frames restarted mid-capture
//   overrun_count  saturating count of frame starts dropped while emitting
//
// Output stream handshake: a sample transfers on a rising clock edge where
// sample_valid and sample_ready are both high. While sample_valid is high and
// sample_ready is low, sample_data/sample_channel/sample_last hold stable, and
// sample_valid only drops after the transfer of the last sample (or on reset).

module ads131_frame_unpacker #(
  parameter int          NUM_CHANNELS  = 4,
  parameter logic [15:0] STATUS_MASK   = 16'hFF00,
  parameter logic [15:0] STATUS_EXPECT = 16'h2200
) (
  input  logic        system_clock,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        word_valid,
  input  logic [31:0] word_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [31:0] sample_data,
  output logic [2:0]  sample_channel,
  output logic        sample_last,
  output logic [15:0] status_word,
  output logic        status_valid,
  output logic        status_error,
  output logic [7:0]  abort_count,
  output logic [7:0]  overrun_count
);

  // Buffer is addressed with exactly as many index bits as the channel count
  // needs, so the array depth is rounded up to a power of two.
  localparam int          IDX_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int          BUF_DEPTH = 1 << IDX_W;
  localparam logic [2:0]  LAST_CH   = 3'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_STATUS   = 2'd1,
    S_CHANNELS = 2'd2,
    S_EMIT     = 2'd3
  } state_t;

  state_t      state;
  logic [2:0]  ch_cnt;
  logic [2:0]  emit_idx;
  logic [31:0] buffer [BUF_DEPTH];

  logic        status_ok;
  logic        capture_word;
  logic        handshake;
  logic        unused_word_bits;

  assign status_ok    = ((word_data[31:16] & STATUS_MASK) == STATUS_EXPECT);
  // A word arriving together with frame_start belongs to no frame.
  assign capture_word = (state == S_CHANNELS) && word_valid && !frame_start;
  assign handshake    = (state == S_EMIT) && sample_ready;

  // The low byte of each channel word carries no sample bits.
  assign unused_word_bits = ^word_data[7:0];

  // Stream outputs are decoded from registered state only, so they are
  // glitch-free and fall to zero as soon as reset clears the state.
  assign sample_valid   = (state == S_EMIT);
  assign sample_data    = (state == S_EMIT) ? buffer[emit_idx[IDX_W-1:0]] : 32'd0;
  assign sample_channel = (state == S_EMIT) ? emit_idx : 3'd0;
  assign sample_last    = (state == S_EMIT) && (emit_idx == LAST_CH);

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      ch_cnt        <= 3'd0;
      emit_idx      <= 3'd0;
      status_word   <= 16'd0;
      status_valid  <= 1'b0;
      status_error  <= 1'b0;
      abort_count   <= 8'd0;
      overrun_count <= 8'd0;
    end else begin
      status_valid <= 1'b0;
      status_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state <= S_STATUS;
          end
        end

        S_STATUS: begin
          if (frame_start) begin
            // Restart: stay waiting for a fresh status word.
            if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
          end else if (word_valid) begin
            status_word  <= word_data[31:16];
            status_valid <= 1'b1;
            if (status_ok) begin
              state  <= S_CHANNELS;
              ch_cnt <= 3'd0;
            end else begin
              status_error <= 1'b1;
              state        <= S_IDLE;
            end
          end
        end

        S_CHANNELS: begin
          if (frame_start) begin
            if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
            state  <= S_STATUS;
            ch_cnt <= 3'd0;
          end else if (word_valid) begin
            if (ch_cnt == LAST_CH) begin
              state    <= S_EMIT;
              emit_idx <= 3'd0;
              ch_cnt   <= 3'd0;
            end else begin
              ch_cnt <= ch_cnt + 3'd1;
            end
          end
        end

        S_EMIT: begin
          // A new frame cannot be captured while the buffer is still draining.
          if (frame_start && (overrun_count != 8'hFF)) begin
            overrun_count <= overrun_count + 8'd1;
          end
          if (handshake) begin
            if (emit_idx == LAST_CH) begin
              state    <= S_IDLE;
              emit_idx <= 3'd0;
            end else begin
              emit_idx <= emit_idx + 3'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Sample storage needs no reset: it is only read in S_EMIT, which is only
  // reached after every entry of the frame has been written.
  always_ff @(posedge system_clock) begin
    if (capture_word) begin
      buffer[ch_cnt[IDX_W-1:0]] <= {{8{word_data[31]}}, word_data[31:8]};
    end
  end

endmodule

// File: tb/tb_ads131_frame_unpacker.sv
// Testbench for ads131_frame_unpacker (NUM_CHANNELS=4, default status check).
// Inputs change 1 ns after the rising edge; outputs are checked at that
// point or on the falling edge. A falling-edge monitor compares every stream
// transfer against the expected queue, so lost or duplicated samples show up.

module tb_ads131_frame_unpacker;

  logic        system_clock;
  logic        reset;
  logic        frame_start;
  logic        word_valid;
  logic [31:0] word_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] sample_data;
  logic [2:0]  sample_channel;
  logic        sample_last;
  logic [15:0] status_word;
  logic        status_valid;
  logic        status_error;
  logic [7:0]  abort_count;
  logic [7:0]  overrun_count;

  int checks;
  int failures;

  // Expected transfers: {last, channel[2:0], data[31:0]}
  logic [35:0] exp_q[$];

  ads131_frame_unpacker #(
    .NUM_CHANNELS (4),
    .STATUS_MASK  (16'hFF00),
    .STATUS_EXPECT(16'h2200)
  ) dut (
    .system_clock  (system_clock),
    .reset         (reset),
    .frame_start   (frame_start),
    .word_valid    (word_valid),
    .word_data     (word_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .sample_data   (sample_data),
    .sample_channel(sample_channel),
    .sample_last   (sample_last),
    .status_word   (status_word),
    .status_valid  (status_valid),
    .status_error  (status_error),
    .abort_count   (abort_count),
    .overrun_count (overrun_count)
  );

  // ---------------- clock / reset ----------------
  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] status;
    logic [31:0] ch [4];
    logic        bad;
    logic [15:0] st;
    logic [31:0] s [4];
  } vec_t;

  vec_t vecs [5];

  task automatic set_vec(input int i, input logic [31:0] status,
                         input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] c3,
                         input logic bad, input logic [15:0] st,
                         input logic [31:0] s0, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] s3);
    vecs[i].status = status;
    vecs[i].ch[0] = c0; vecs[i].ch[1] = c1; vecs[i].ch[2] = c2; vecs[i].ch[3] = c3;
    vecs[i].bad = bad;
    vecs[i].st  = st;
    vecs[i].s[0] = s0; vecs[i].s[1] = s1; vecs[i].s[2] = s2; vecs[i].s[3] = s3;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every transfer must match the head of the expected queue.
  always @(negedge system_clock) begin
    if (!reset && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", {sample_last, sample_channel, sample_data}, 36'd0);
      end else begin
        chk("sample_transfer", {sample_last, sample_channel, sample_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge system_clock);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    word_data  = w;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    word_data  = 32'd0;
  endtask

  task automatic push_frame(input int i);
    for (int c = 0; c < 4; c++) begin
      exp_q.push_back({(c == 3), 3'(c), vecs[i].s[c]});
    end
  endtask

  // Sends frame i up to its last channel word (status checks included).
  task automatic load_frame(input int i);
    pulse_start();
    send_word(vecs[i].status);
    chk("status_valid", 36'(status_valid), 36'd1);
    chk("status_error", 36'(status_error), 36'(vecs[i].bad));
    chk("status_word", 36'(status_word), 36'(vecs[i].st));
    for (int c = 0; c < 4; c++) send_word(vecs[i].ch[c]);
  endtask

  // ---------------- test ----------------
  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    frame_start = 1'b0;
    word_valid = 1'b0;
    word_data = 32'd0;
    sample_ready = 1'b1;

    set_vec(0, 32'h2200_0000, 32'h7FFF_FF00, 32'h8000_0000, 32'h0000_0100, 32'hFFFF_FFAB,
            1'b0, 16'h2200, 32'h007F_FFFF, 32'hFF80_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    set_vec(1, 32'h22AB_1234, 32'h1234_5678, 32'h8765_43FF, 32'h0000_00FF, 32'hFFFF_FF00,
            1'b0, 16'h22AB, 32'h0012_3456, 32'hFF87_6543, 32'h0000_0000, 32'hFFFF_FFFF);
    set_vec(2, 32'h0655_0000, 32'h1111_1100, 32'h2222_2200, 32'h3333_3300, 32'h4444_4400,
            1'b1, 16'h0655, 32'h0, 32'h0, 32'h0, 32'h0);
    set_vec(3, 32'h2300_0000, 32'h7FFF_FF00, 32'h8000_0000, 32'h0000_0100, 32'hFFFF_FFAB,
            1'b1, 16'h2300, 32'h0, 32'h0, 32'h0, 32'h0);
    set_vec(4, 32'h22FF_FFFF, 32'h0000_0001, 32'h7F00_0000, 32'h80FF_FF00, 32'hC000_0000,
            1'b0, 16'h22FF, 32'h0000_0000, 32'h007F_0000, 32'hFF80_FFFF, 32'hFFC0_0000);

    repeat (3) @(posedge system_clock);
    #1;
    chk("reset_outputs",
        {sample_valid, sample_data, sample_channel, sample_last, status_valid, status_error},
        36'd0);
    chk("reset_status_word", 36'(status_word), 36'd0);
    chk("reset_counts", 36'({abort_count, overrun_count}), 36'd0);
    reset = 1'b0;
    step();

    // Table: full frames with ready held high.
    for (int i = 0; i < 5; i++) begin
      if (!vecs[i].bad) push_frame(i);
      load_frame(i);
      if (vecs[i].bad) begin
        chk("bad_no_sample", 36'(sample_valid), 36'd0);
        step();
        chk("bad_no_sample_later", 36'(sample_valid), 36'd0);
      end else begin
        for (int c = 0; c < 4; c++) begin
          chk("emit_cycle_valid", 36'(sample_valid), 36'd1);
          chk("emit_cycle_channel", 36'(sample_channel), 36'(c));
          step();
        end
        chk("emit_done", 36'(sample_valid), 36'd0);
      end
      step();
    end

    // Backpressure on channel 1 for 5 cycles.
    push_frame(0);
    load_frame(0);
    step();
    sample_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {sample_valid, sample_channel, sample_data}, {1'b1, 3'd1, 32'hFF80_0000});
      step();
    end
    sample_ready = 1'b1;
    repeat (3) step();
    chk("bp_done", 36'(sample_valid), 36'd0);
    step();

    // Abort after two channel words; the restarting frame_start coincides
    // with a word that must be ignored.
    push_frame(1);
    pulse_start();
    send_word(32'h2200_0000);
    send_word(32'hAAAA_AA00);
    send_word(32'hBBBB_BB00);
    frame_start = 1'b1;
    word_valid  = 1'b1;
    word_data   = 32'hCCCC_CC00;
    step();
    frame_start = 1'b0;
    word_valid  = 1'b0;
    chk("abort_count", 36'(abort_count), 36'd1);
    chk("abort_no_sample", 36'(sample_valid), 36'd0);
    send_word(vecs[1].status);
    chk("abort_status_valid", 36'(status_valid), 36'd1);
    for (int c = 0; c < 4; c++) send_word(vecs[1].ch[c]);
    chk("abort_emit_latency", 36'(sample_valid), 36'd1);
    repeat (5) step();
    chk("abort_q_empty", 36'(exp_q.size()), 36'd0);

    // Overrun: 300 frame_start pulses (plus stray words) while stalled.
    sample_ready = 1'b0;
    load_frame(4);
    for (int k = 0; k < 300; k++) begin
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      if (k == 9) chk("overrun_count_10", 36'(overrun_count), 36'd10);
      send_word(32'h5555_5500);
    end
    chk("overrun_sat", 36'(overrun_count), 36'd255);
    chk("overrun_hold", {sample_valid, sample_channel, sample_data}, {1'b1, 3'd0, 32'h0000_0000});
    push_frame(4);
    sample_ready = 1'b1;
    repeat (4) step();
    chk("overrun_done", 36'(sample_valid), 36'd0);
    repeat (2) step();
    chk("overrun_idle", 36'(sample_valid), 36'd0);

    // Asynchronous reset while a sample is waiting.
    sample_ready = 1'b0;
    load_frame(0);
    step();
    chk("pre_reset_valid", 36'(sample_valid), 36'd1);
    #3 reset = 1'b1;
    #1;
    chk("async_reset_stream",
        {sample_valid, sample_data, sample_channel, sample_last}, 36'd0);
    chk("async_reset_counts", 36'({abort_count, overrun_count}), 36'd0);
    chk("async_reset_status", 36'(status_word), 36'd0);
    step();
    reset = 1'b0;
    sample_ready = 1'b1;
    step();

    // Fresh frame after reset.
    push_frame(1);
    load_frame(1);
    repeat (6) step();
    chk("final_q_empty", 36'(exp_q.size()), 36'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
